// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and default widths.
package mac_sequencer_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_RESULT_WIDTH = 16;
  localparam int DEFAULT_LENGTH_WIDTH = 8;
  localparam int WEIGHT_WIDTH         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_sequencer_multiply_and_add.sv
// Combinational multiply-accumulate step: result = add_value + input_value * weight_value,
// unsigned, wrapping modulo 2^RESULT_WIDTH.
module multiply_and_add
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH
) (
  input  logic [RESULT_WIDTH-1:0] add_value,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [WEIGHT_WIDTH-1:0] weight_value,
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int PRODUCT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

  logic [PRODUCT_WIDTH-1:0] product;

  assign product = PRODUCT_WIDTH'(input_value) * PRODUCT_WIDTH'(weight_value);

  // Truncating the product before the add is harmless since the sum wraps anyway.
  assign result = RESULT_WIDTH'(product) + add_value;

endmodule

// File: rtl/mac_sequencer.sv
// Walks one multiply_and_add across a vector to produce a dot product,
// returning the sum over a valid/ready handshake.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
  parameter int LENGTH_WIDTH = DEFAULT_LENGTH_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] vector_length,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [WEIGHT_WIDTH-1:0] weight_value,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [RESULT_WIDTH-1:0] result_value
);

  state_t                  state;
  logic [RESULT_WIDTH-1:0] accumulator;
  logic [RESULT_WIDTH-1:0] mac_sum;
  logic [LENGTH_WIDTH-1:0] counter;
  logic [LENGTH_WIDTH-1:0] length;
  logic                    beat;
  logic                    last_beat;

  multiply_and_add #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_mac (
    .add_value   (accumulator),
    .input_value (input_value),
    .weight_value(weight_value),
    .result      (mac_sum)
  );

  assign beat         = in_valid && in_ready;
  assign last_beat    = (counter == length - LENGTH_WIDTH'(1));
  assign result_value = accumulator;

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      accumulator  <= '0;
      counter      <= '0;
      length       <= '0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accumulator <= '0;
            counter     <= '0;
            length      <= vector_length;
            busy        <= 1'b1;
            if (vector_length != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            accumulator <= mac_sum;
            counter     <= counter + LENGTH_WIDTH'(1);
            if (last_beat) begin
              state        <= DONE;
              in_ready     <= 1'b0;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          in_ready     <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed table, reset corner cases and
// randomized runs checked against a plain-arithmetic dot-product model.
module tb_mac_sequencer;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] vector_length = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] input_value = '0;
  logic [7:0]    weight_value = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [RW-1:0] result_value;

  int checks = 0;
  int errors = 0;

  logic [7:0] stim_a [256];
  logic [7:0] stim_w [256];

  typedef struct {
    int              len;
    int              gap;
    int              rdy_delay;
    bit              pulse;
    logic [3:0][7:0] a;
    logic [3:0][7:0] w;
    logic [15:0]     exp_value;
    int              exp_latency;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  mac_sequencer #(
    .DATA_WIDTH  (DW),
    .RESULT_WIDTH(RW),
    .LENGTH_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .vector_length(vector_length),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_value  (input_value),
    .weight_value (weight_value),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_value (result_value)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one command using stim_a/stim_w; pairs are offered after 'gap' idle cycles each,
  // junk pairs keep in_valid high past the last element to expose over-consumption.
  task automatic applyStimulus(input int len, input int gap, input int rdy_delay, input bit pulse,
                               input logic [15:0] exp_value, input int exp_latency, input string tag);
    int          cyc;
    int          idx;
    int          gapcnt;
    int          beats;
    bit          seen;
    bit          stable;
    logic [15:0] got;
    @(negedge clk);
    start = 1'b1;
    vector_length = LW'(len);
    result_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vector_length = '0;
    checkOutput({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 1;
    idx = 0;
    gapcnt = gap;
    beats = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      if (result_valid) begin
        seen = 1'b1;
      end else begin
        start = pulse && (cyc == 2);
        vector_length = (pulse && cyc == 2) ? LW'(3) : LW'(0);
        if (gapcnt > 0) begin
          in_valid = 1'b0;
          gapcnt--;
        end else begin
          in_valid = 1'b1;
          if (idx < len) begin
            input_value = stim_a[idx];
            weight_value = stim_w[idx];
          end else begin
            input_value = 8'hFF;
            weight_value = 8'hFF;
          end
        end
        if (in_valid && in_ready) begin
          beats++;
          idx++;
          gapcnt = gap;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    vector_length = '0;
    if (!seen) begin
      checkOutput({tag, " timeout"}, 64'd0, 64'd1);
      return;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_latency));
    checkOutput({tag, " beats"}, 64'(beats), 64'(len));
    checkOutput({tag, " result"}, 64'(result_value), 64'(exp_value));
    checkOutput({tag, " in_ready in done"}, 64'(in_ready), 64'd0);
    got = result_value;
    stable = 1'b1;
    repeat (rdy_delay) begin
      @(negedge clk);
      if (!result_valid || result_value !== got) stable = 1'b0;
    end
    checkOutput({tag, " held"}, 64'(stable), 64'd1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, " valid dropped"}, 64'(result_valid), 64'd0);
    checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, " stays idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned acc;
    int          len;
    int          gap;
    int          rdy;

    vecs[0] = '{3, 0, 0, 1'b0, {8'd0, 8'd5, 8'd3, 8'd1}, {8'd0, 8'd6, 8'd4, 8'd2}, 16'd44, 4};
    vecs[1] = '{2, 2, 5, 1'b0, {8'd0, 8'd0, 8'd20, 8'd10}, {8'd0, 8'd0, 8'd3, 8'd10}, 16'd160, 7};
    vecs[2] = '{2, 0, 0, 1'b0, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd255, 8'd255}, 16'd64514, 3};
    vecs[3] = '{0, 0, 1, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 16'd0, 1};
    vecs[4] = '{4, 0, 0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 16'd30, 5};

    repeat (3) @(negedge clk);
    checkOutput("in reset busy", 64'(busy), 64'd0);
    checkOutput("in reset result_value", 64'(result_value), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle busy", 64'(busy), 64'd0);
      checkOutput("idle in_ready", 64'(in_ready), 64'd0);
      checkOutput("idle result_valid", 64'(result_valid), 64'd0);
      checkOutput("idle result_value", 64'(result_value), 64'd0);
    end

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        stim_a[i] = vecs[v].a[i];
        stim_w[i] = vecs[v].w[i];
      end
      applyStimulus(vecs[v].len, vecs[v].gap, vecs[v].rdy_delay, vecs[v].pulse,
                    vecs[v].exp_value, vecs[v].exp_latency, $sformatf("vec%0d", v));
    end

    // Abort a four-element run after two beats with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    vector_length = 8'd4;
    @(negedge clk);
    start = 1'b0;
    vector_length = '0;
    in_valid = 1'b1;
    input_value = 8'd5;
    weight_value = 8'd5;
    @(negedge clk);
    input_value = 8'd6;
    weight_value = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort in_ready", 64'(in_ready), 64'd0);
    checkOutput("abort result_valid", 64'(result_valid), 64'd0);
    checkOutput("abort result_value", 64'(result_value), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stim_a[0] = 8'd7;
    stim_w[0] = 8'd3;
    applyStimulus(1, 0, 0, 1'b0, 16'd21, 2, "after abort");

    for (int r = 0; r < 30; r++) begin
      len = (r == 0) ? 255 : int'($urandom_range(0, 12));
      gap = (r == 0) ? 0 : int'($urandom_range(0, 2));
      rdy = int'($urandom_range(0, 3));
      acc = 0;
      for (int i = 0; i < len; i++) begin
        stim_a[i] = 8'($urandom);
        stim_w[i] = 8'($urandom);
        acc = acc + int'(stim_a[i]) * int'(stim_w[i]);
      end
      applyStimulus(len, gap, rdy, (r % 5) == 3, 16'(acc % 65536), len * (gap + 1) + 1,
                    $sformatf("rand%0d len%0d", r, len));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
